// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one load/store in flight, fixed LATENCY, valid/ready on both channels.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses raise rsp_error instead of being aligned down.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_address,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  input  logic        setup_write,
  input  logic [31:0] setup_address,
  input  logic [31:0] setup_data_in
);
  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  count_reg;
  logic [31:0]    addr_reg, wdata_reg;
  logic           write_reg, uns_reg;
  logic [1:0]     size_reg;
  logic [31:0]    rdata_reg;
  logic           error_reg;
  logic           accept, commit;

  logic [31:0]    mem [0:DEPTH_WORDS-1];

  // Address decode of the captured request
  logic [31:0]    eff_addr;
  logic [29:0]    word_off;
  logic [IW-1:0]  idx;
  logic           in_range, req_err;

  always_comb begin
`ifdef DMEM_MISALIGN_TRAP_EN
    eff_addr = addr_reg;
`else
    // Misaligned low bits are dropped so the access lands on its natural boundary
    case (size_reg)
      2'b01:   eff_addr = {addr_reg[31:1], 1'b0};
      2'b10:   eff_addr = {addr_reg[31:2], 2'b00};
      default: eff_addr = addr_reg;
    endcase
`endif
    word_off = 30'((eff_addr - ADDR_BASE) >> 2);
    idx      = word_off[IW-1:0];
    in_range = (eff_addr >= ADDR_BASE) && ({2'b00, word_off} < 32'(DEPTH_WORDS));
    req_err  = !in_range || (size_reg == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((size_reg == 2'b01 && addr_reg[0]) || (size_reg == 2'b10 && addr_reg[1:0] != 2'b00))
      req_err = 1'b1;
`endif
  end

  // Setup port decode
  logic [29:0]    setup_word;
  logic           setup_ok;
  always_comb begin
    setup_word = 30'((setup_address - ADDR_BASE) >> 2);
    setup_ok   = (setup_address >= ADDR_BASE) && ({2'b00, setup_word} < 32'(DEPTH_WORDS));
  end

  // Lane selection and extension for loads; byte enables for stores
  logic [31:0]    rd_word, load_ext, wd;
  logic [7:0]     lane_byte;
  logic [15:0]    lane_half;
  logic [3:0]     be;

  always_comb begin
    rd_word   = mem[idx];
    lane_byte = rd_word[8*eff_addr[1:0] +: 8];
    lane_half = rd_word[16*eff_addr[1] +: 16];
    case (size_reg)
      2'b00: begin
        load_ext = uns_reg ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
        be       = 4'b0001 << eff_addr[1:0];
        wd       = {4{wdata_reg[7:0]}};
      end
      2'b01: begin
        load_ext = uns_reg ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
        be       = eff_addr[1] ? 4'b1100 : 4'b0011;
        wd       = {2{wdata_reg[15:0]}};
      end
      default: begin
        load_ext = rd_word;
        be       = 4'b1111;
        wd       = wdata_reg;
      end
    endcase
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = reset && !setup_write;
        if (req_valid && reset && !setup_write) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (count_reg == '0) begin
          commit     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      write_reg <= 1'b0;
      uns_reg   <= 1'b0;
      size_reg  <= 2'b00;
      rdata_reg <= '0;
      error_reg <= 1'b0;
    end else begin
      if (accept) begin
        count_reg <= CW'(LATENCY - 1);
        addr_reg  <= req_address;
        wdata_reg <= req_wdata;
        write_reg <= req_write;
        uns_reg   <= req_unsigned;
        size_reg  <= req_size;
      end else if (state_reg == BUSY && count_reg != '0) begin
        count_reg <= count_reg - 1'b1;
      end
      if (commit) begin
        rdata_reg <= (req_err || write_reg) ? 32'h0 : load_ext;
        error_reg <= req_err;
      end
    end
  end

  // Setup write is issued last so it overrides a same-word store commit
  always_ff @(posedge clock) begin
    if (commit && write_reg && !req_err) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
    end
    if (setup_write && setup_ok) mem[setup_word[IW-1:0]] <= setup_data_in;
  end

  assign rsp_rdata = rdata_reg;
  assign rsp_error = error_reg;
endmodule
